// File: rtl/alarm_sequencer.sv
// Alarm path controller: detects the alarm-time match and walks the alarm through
// armed, ringing, snooze and done phases, with minute-based snooze and ring timeouts.
module alarm_sequencer #(
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] time_Dat,
  input  logic [13:0] alm_Dat,
  input  logic        alm_Enable,
  input  logic        snooze_Btn,
  input  logic        puzzle_Solved,
  input  logic        ena_60_Sec,
  output logic        alm_Sound,
  output logic        puzzle_Start,
  output logic        snooze_Active,
  output logic [2:0]  snooze_Count,
  output logic [2:0]  state_Out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RINGING = 3'd2,
    SNOOZE  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [3:0] SNZ_MIN  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_TO  = 4'(RING_TIMEOUT_MIN);
  localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic       match_q, snz_q;
  logic       puzzle_start_q, puzzle_start_d;
  logic [3:0] ring_tmr_q, ring_tmr_d;
  logic [3:0] snz_tmr_q, snz_tmr_d;
  logic [2:0] snz_cnt_q, snz_cnt_d;

  logic       match, trigger, snz_rise;
  logic [3:0] ring_next, snz_next;

  assign match     = (time_Dat == alm_Dat);
  assign trigger   = match && !match_q;
  assign snz_rise  = snooze_Btn && !snz_q;
  assign ring_next = (ring_tmr_q == 4'hF) ? 4'hF : ring_tmr_q + 4'd1;
  assign snz_next  = (snz_tmr_q == 4'hF) ? 4'hF : snz_tmr_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      IDLE: begin
        if (alm_Enable) state_d = ARMED;
      end
      ARMED: begin
        if (!alm_Enable) begin
          state_d = IDLE;
        end else if (trigger) begin
          state_d    = RINGING;
          ring_tmr_d = 4'd0;
          snz_cnt_d  = 3'd0;
        end
      end
      RINGING: begin
        if (!alm_Enable) begin
          state_d = IDLE;
        end else if (puzzle_Solved) begin
          state_d = DONE;
        end else if (ena_60_Sec && (ring_next >= RING_TO)) begin
          state_d = DONE;
        end else if (snz_rise && (snz_cnt_q < SNZ_MAX)) begin
          state_d   = SNOOZE;
          snz_cnt_d = snz_cnt_q + 3'd1;
          snz_tmr_d = 4'd0;
        end else if (ena_60_Sec) begin
          ring_tmr_d = ring_next;
        end
      end
      SNOOZE: begin
        // puzzle completion is deliberately not honoured while snoozing
        if (!alm_Enable) begin
          state_d = IDLE;
        end else if (ena_60_Sec) begin
          snz_tmr_d = snz_next;
          if (snz_next >= SNZ_MIN) begin
            state_d    = RINGING;
            ring_tmr_d = 4'd0;
          end
        end
      end
      DONE: begin
        if (!alm_Enable) state_d = IDLE;
        else if (!match) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
    puzzle_start_d = (state_d == RINGING) && (state_q != RINGING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      match_q        <= 1'b0;
      snz_q          <= 1'b0;
      puzzle_start_q <= 1'b0;
      ring_tmr_q     <= 4'd0;
      snz_tmr_q      <= 4'd0;
      snz_cnt_q      <= 3'd0;
    end else begin
      state_q        <= state_d;
      match_q        <= match;
      snz_q          <= snooze_Btn;
      puzzle_start_q <= puzzle_start_d;
      ring_tmr_q     <= ring_tmr_d;
      snz_tmr_q      <= snz_tmr_d;
      snz_cnt_q      <= snz_cnt_d;
    end
  end

  assign alm_Sound     = (state_q == RINGING);
  assign snooze_Active = (state_q == SNOOZE);
  assign puzzle_Start  = puzzle_start_q;
  assign snooze_Count  = snz_cnt_q;
  assign state_Out     = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: vector table for the basic flows, hand-written
// sequences for snooze limit, ring timeout and reset during snooze.
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] time_Dat, alm_Dat;
  logic        alm_Enable, snooze_Btn, puzzle_Solved, ena_60_Sec;
  logic        alm_Sound, puzzle_Start, snooze_Active;
  logic [2:0]  snooze_Count, state_Out;

  int tests_run = 0;
  int tests_failed = 0;

  alarm_sequencer #(.SNOOZE_MIN(5), .MAX_SNOOZE(3), .RING_TIMEOUT_MIN(10)) dut (
    .clk(clk), .rst(rst), .time_Dat(time_Dat), .alm_Dat(alm_Dat),
    .alm_Enable(alm_Enable), .snooze_Btn(snooze_Btn), .puzzle_Solved(puzzle_Solved),
    .ena_60_Sec(ena_60_Sec), .alm_Sound(alm_Sound), .puzzle_Start(puzzle_Start),
    .snooze_Active(snooze_Active), .snooze_Count(snooze_Count), .state_Out(state_Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [13:0] t;
    logic [13:0] a;
    logic        en;
    logic        snz;
    logic        solved;
    logic        tick;
    logic [2:0]  st;
    logic        snd;
    logic        ps;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int snd, input int ps, input int cnt);
    chk({tag, " state"},  int'(state_Out), st);
    chk({tag, " sound"},  int'(alm_Sound), snd);
    chk({tag, " pstart"}, int'(puzzle_Start), ps);
    chk({tag, " snzact"}, int'(snooze_Active), (st == 3) ? 1 : 0);
    chk({tag, " snzcnt"}, int'(snooze_Count), cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    ena_60_Sec = 1'b1;
    step();
    ena_60_Sec = 1'b0;
  endtask

  initial begin
    //           rst  t    a    en snz sol tk  st snd ps cnt
    vecs[0]  = '{1, 729, 730, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 729, 730, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 729, 730, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0, 730, 730, 1, 0, 0, 0, 2, 1, 1, 0};
    vecs[4]  = '{0, 730, 730, 1, 0, 0, 0, 2, 1, 0, 0};
    vecs[5]  = '{0, 730, 730, 1, 0, 1, 0, 4, 0, 0, 0};
    vecs[6]  = '{0, 730, 730, 1, 0, 0, 0, 4, 0, 0, 0};
    vecs[7]  = '{0, 731, 730, 1, 0, 0, 0, 1, 0, 0, 0};
    // enabling inside the matching minute must not ring
    vecs[8]  = '{0, 800, 800, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 800, 800, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 800, 800, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[11] = '{0, 801, 800, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 800, 800, 1, 0, 0, 0, 2, 1, 1, 0};
    vecs[13] = '{0, 800, 800, 1, 0, 0, 0, 2, 1, 0, 0};
    // solve wins over a simultaneous snooze press
    vecs[14] = '{0, 800, 800, 1, 1, 1, 0, 4, 0, 0, 0};
    vecs[15] = '{0, 801, 800, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[16] = '{0, 800, 800, 1, 0, 0, 0, 2, 1, 1, 0};
    // disable wins over a simultaneous solve
    vecs[17] = '{0, 800, 800, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[18] = '{0, 801, 800, 1, 0, 0, 0, 1, 0, 0, 0};

    rst = 1'b1; time_Dat = 14'd0; alm_Dat = 14'd0; alm_Enable = 1'b0;
    snooze_Btn = 1'b0; puzzle_Solved = 1'b0; ena_60_Sec = 1'b0;
    step();

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst; time_Dat = vecs[i].t; alm_Dat = vecs[i].a;
      alm_Enable = vecs[i].en; snooze_Btn = vecs[i].snz;
      puzzle_Solved = vecs[i].solved; ena_60_Sec = vecs[i].tick;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].snd, vecs[i].ps, vecs[i].cnt);
    end
    snooze_Btn = 1'b0; puzzle_Solved = 1'b0;

    // snooze limit: three accepted presses, fourth ignored
    time_Dat = 14'd800;
    step();
    chk_all("snzlim ring", 2, 1, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      snooze_Btn = 1'b1;
      step();
      chk_all($sformatf("snz%0d enter", k), 3, 0, 0, k);
      snooze_Btn = 1'b0;
      step();
      for (int m = 1; m <= 4; m++) begin
        tick_once();
        step();
      end
      chk_all($sformatf("snz%0d hold", k), 3, 0, 0, k);
      tick_once();
      chk_all($sformatf("snz%0d rering", k), 2, 1, 1, k);
      step();
      chk_all($sformatf("snz%0d ps drop", k), 2, 1, 0, k);
    end
    snooze_Btn = 1'b1;
    step();
    chk_all("snz4 ignored", 2, 1, 0, 3);
    snooze_Btn = 1'b0;
    step();

    // ring timeout on the 10th minute tick
    for (int m = 1; m <= 9; m++) begin
      tick_once();
      step();
    end
    chk_all("timeout 9", 2, 1, 0, 3);
    tick_once();
    chk_all("timeout 10", 4, 0, 0, 3);

    // reset during snooze with two snoozes used
    time_Dat = 14'd801;
    step();
    chk_all("rearm", 1, 0, 0, 3);
    time_Dat = 14'd800;
    step();
    chk_all("ring2", 2, 1, 1, 0);
    snooze_Btn = 1'b1;
    step();
    snooze_Btn = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      tick_once();
    end
    chk_all("ring2 rering", 2, 1, 1, 1);
    snooze_Btn = 1'b1;
    step();
    snooze_Btn = 1'b0;
    chk_all("snz cnt2", 3, 0, 0, 2);
    puzzle_Solved = 1'b1;
    step();
    chk_all("solve in snooze", 3, 0, 0, 2);
    puzzle_Solved = 1'b0;
    rst = 1'b1;
    step();
    chk_all("mid reset", 0, 0, 0, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
